// File: rtl/alu_exec_stage.sv
// alu_exec_stage: EX-stage ALU driven by the 3-bit ALU control code.
// Each result is stored with its zero/ovf flags and rd index in a 2-entry valid/ready output buffer.
module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       aluctrl,
  input  logic [4:0]       rd_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic [4:0]       rd_out,
  output logic             busy
);
  localparam logic [1:0] FULL = 2'(DEPTH);
  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             z;
    logic             v;
    logic [4:0]       rd;
  } entry_t;
  entry_t head_q, head_d, tail_q, tail_d, new_e;
  logic [1:0] count_q, count_d;
  logic [WIDTH-1:0] sum, dif, res;
  logic ov, acc, deq;
  always_comb begin
    sum = op_a + op_b;
    dif = op_a - op_b;
    res = aluctrl == 3'd0 ? sum :
          aluctrl == 3'd1 ? dif :
          aluctrl == 3'd2 ? op_a & op_b :
          aluctrl == 3'd3 ? op_a | op_b :
          aluctrl == 3'd4 ? op_a ^ op_b :
          aluctrl == 3'd5 ? ~(op_a | op_b) :
          aluctrl == 3'd6 ? {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)} : '0;
    ov = aluctrl == 3'd0 ? (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]) :
         aluctrl == 3'd1 ? (op_a[WIDTH-1] != op_b[WIDTH-1]) && (dif[WIDTH-1] != op_a[WIDTH-1]) : 1'b0;
    new_e.res = res;
    new_e.z   = res == '0;
    new_e.v   = ov;
    new_e.rd  = rd_in;
  end
  assign out_valid = count_q != 2'd0;
  assign busy      = out_valid;
  assign in_ready  = (count_q != FULL) || out_ready;
  assign acc       = in_valid && in_ready && !flush;
  assign deq       = out_valid && out_ready;
  // A new entry lands in the head when the buffer is (or becomes) empty ahead of it, else in the tail.
  always_comb begin
    count_d = flush ? 2'd0 : count_q + {1'b0, acc} - {1'b0, deq};
    head_d  = flush ? head_q :
              deq ? (count_q == FULL ? tail_q : acc ? new_e : head_q) :
              (acc && count_q == 2'd0) ? new_e : head_q;
    tail_d  = (!flush && acc && count_q != 2'd0 && ((count_q == FULL) == deq)) ? new_e : tail_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end
  assign result = head_q.res;
  assign zero   = head_q.z;
  assign ovf    = head_q.v;
  assign rd_out = head_q.rd;
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed self-checking bench for alu_exec_stage.
module tb_alu_exec_stage;
  logic        clk = 0, rst_n = 0, in_valid = 0, flush = 0, out_ready = 0;
  logic        in_ready, out_valid, zero, ovf, busy;
  logic [31:0] op_a = 0, op_b = 0, result;
  logic [2:0]  aluctrl = 0;
  logic [4:0]  rd_in = 0, rd_out;
  int total = 0, bad = 0;

  alu_exec_stage #(.WIDTH(32), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .aluctrl(aluctrl), .rd_in(rd_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
    .ovf(ovf), .rd_out(rd_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] c, input logic [4:0] rd);
    in_valid = v; op_a = a; op_b = b; aluctrl = c; rd_in = rd;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0 ||
        zero !== 1'b0 || ovf !== 1'b0 || rd_out !== 5'd0) begin
      bad++;
      $display("FAIL reset_state: valid=%b busy=%b ready=%b result=%h zero=%b ovf=%b rd=%0d, want 0 0 1 0 0 0 0",
               out_valid, busy, in_ready, result, zero, ovf, rd_out);
    end
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_ops();
    logic [31:0] ea [10] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'd5,
                             32'd3, 32'hF0F01234, 32'hF0F01234, 32'hF0F01234, 32'hF0F01234};
    logic [31:0] eb [10] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd5,
                             32'd4, 32'h0FF05678, 32'h0FF05678, 32'h0FF05678, 32'h0FF05678};
    logic [2:0]  ec [10] = '{3'd0, 3'd1, 3'd1, 3'd6, 3'd1, 3'd7, 3'd2, 3'd3, 3'd4, 3'd5};
    logic [31:0] er [10] = '{32'h80000000, 32'h7FFFFFFE, 32'h7FFFFFFF, 32'd1, 32'd0,
                             32'd0, 32'h00F01230, 32'hFFF0567C, 32'hFF00444C, 32'h000FA983};
    logic        ez [10] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    logic        ev [10] = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      drive(1, ea[i], eb[i], ec[i], 5'(i + 1));
      tick();
      drive(0, 0, 0, 0, 0);
      total++;
      if (out_valid !== 1'b1 || result !== er[i] || zero !== ez[i] || ovf !== ev[i] || rd_out !== 5'(i + 1)) begin
        bad++;
        $display("FAIL op_%0d: valid=%b result=%h zero=%b ovf=%b rd=%0d, want 1 %h %b %b %0d",
                 i, out_valid, result, zero, ovf, rd_out, er[i], ez[i], ev[i], i + 1);
      end
    end
    tick();
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL ops_drain: valid=%b busy=%b, want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    for (int i = 1; i <= 2; i++) begin
      drive(1, 32'(i), 32'(i), 3'd0, 5'(i));
      #1;
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL bp_ready_%0d: in_ready=%b, want 1", i, in_ready);
      end
      tick();
    end
    drive(1, 32'd3, 32'd3, 3'd0, 5'd3);
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || rd_out !== 5'd1 || result !== 32'd2 || busy !== 1'b1) begin
        bad++;
        $display("FAIL bp_stall_%0d: ready=%b valid=%b rd=%0d result=%h busy=%b, want 0 1 1 2 1",
                 k, in_ready, out_valid, rd_out, result, busy);
      end
      tick();
    end
    out_ready = 1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release_ready: in_ready=%b, want 1", in_ready);
    end
    tick();
    drive(0, 0, 0, 0, 0);
    total++;
    if (out_valid !== 1'b1 || rd_out !== 5'd2 || result !== 32'd4) begin
      bad++;
      $display("FAIL bp_second: valid=%b rd=%0d result=%h, want 1 2 4", out_valid, rd_out, result);
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || rd_out !== 5'd3 || result !== 32'd6) begin
      bad++;
      $display("FAIL bp_third: valid=%b rd=%0d result=%h, want 1 3 6", out_valid, rd_out, result);
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_empty: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 0;
    drive(1, 32'd100, 32'd0, 3'd0, 5'd31);
    tick();
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'(i + 10), 32'(i), 3'd0, 5'(i));
      tick();
      total++;
      if (out_valid !== 1'b1 || rd_out !== 5'(i) || result !== 32'(2 * i + 10)) begin
        bad++;
        $display("FAIL b2b_%0d: valid=%b rd=%0d result=%h, want 1 %0d %h",
                 i, out_valid, rd_out, result, i, 2 * i + 10);
      end
    end
    drive(0, 0, 0, 0, 0);
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_count: valid=%b after one drain, want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 0;
    drive(1, 32'd7, 32'd0, 3'd0, 5'd7);
    tick();
    drive(1, 32'd8, 32'd0, 3'd0, 5'd8);
    tick();
    drive(1, 32'd9, 32'd0, 3'd0, 5'd9);
    out_ready = 1;
    flush = 1;
    tick();
    flush = 0;
    drive(0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL flush_empty_%0d: valid=%b busy=%b rd=%0d, want 0 0", k, out_valid, busy, rd_out);
      end
      tick();
    end
    drive(1, 32'd10, 32'd0, 3'd0, 5'd10);
    tick();
    drive(0, 0, 0, 0, 0);
    total++;
    if (out_valid !== 1'b1 || rd_out !== 5'd10 || result !== 32'd10) begin
      bad++;
      $display("FAIL flush_after: valid=%b rd=%0d result=%h, want 1 10 a", out_valid, rd_out, result);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 0;
    drive(1, 32'd1, 32'd2, 3'd0, 5'd5);
    tick();
    drive(1, 32'd3, 32'd4, 3'd0, 5'd6);
    tick();
    drive(0, 0, 0, 0, 0);
    #2;
    rst_n = 0;
    #1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0 || rd_out !== 5'd0) begin
      bad++;
      $display("FAIL reset_mid: valid=%b busy=%b ready=%b result=%h rd=%0d, want 0 0 1 0 0",
               out_valid, busy, in_ready, result, rd_out);
    end
    tick();
    rst_n = 1;
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: valid=%b, want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
